screen: RTL and testbench

SSD1306 128×64 OLED driver for the SPI master board. Runs the panel power-up and reset sequence, then a fixed initialisation command list, then streams the 1024-byte frame continuously over a write-only 4-wire SPI link. Pixel bytes come from an external frame source (font/character renderer) through an address/data pair, read one byte per transfer.

---
 rtl/screen.sv | 188 ++++++++++++++++++
 tb/tb_screen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/screen.sv
// SSD1306 128x64 OLED driver: power-up/reset sequencing, a fixed init command list,
// then continuous 1024-byte frame streaming over a write-only 4-wire SPI link.
module screen #(
    parameter int unsigned STARTUP_WAIT = 32'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_btn,
    output logic       ioSclk,
    output logic       ioSdin,
    output logic       ioCs,
    output logic       ioDc,
    output logic       ioReset,
    output logic [9:0] pixelAddress,
    input  logic [7:0] pixelData
);

    localparam logic [2:0] StInitPower         = 3'd0;
    localparam logic [2:0] StLoadInitCmd       = 3'd1;
    localparam logic [2:0] StSend              = 3'd2;
    localparam logic [2:0] StCheckFinishedInit = 3'd3;
    localparam logic [2:0] StLoadData          = 3'd4;

    localparam logic [31:0] Wait1 = STARTUP_WAIT;
    localparam logic [31:0] Wait2 = STARTUP_WAIT * 2;
    localparam logic [31:0] Wait3 = STARTUP_WAIT * 3;
    localparam logic [4:0]  LastCmd = 5'd24;

    logic [2:0]  state_q, state_d;
    logic [2:0]  next_q, next_d;
    logic [31:0] counter_q, counter_d;
    logic        sclk_q, sclk_d;
    logic        sdin_q, sdin_d;
    logic        cs_q, cs_d;
    logic        dc_q, dc_d;
    logic        panel_rst_q, panel_rst_d;
    logic [9:0]  addr_q, addr_d;
    logic [2:0]  bit_q, bit_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        phase_q, phase_d;
    logic [7:0]  init_cmd;

    // Horizontal addressing mode (20 00) lets the panel wrap its own pointer per frame.
    always_comb begin
        case (idx_q)
            5'd0:    init_cmd = 8'hAE;
            5'd1:    init_cmd = 8'hD5;
            5'd2:    init_cmd = 8'h80;
            5'd3:    init_cmd = 8'hA8;
            5'd4:    init_cmd = 8'h3F;
            5'd5:    init_cmd = 8'hD3;
            5'd6:    init_cmd = 8'h00;
            5'd7:    init_cmd = 8'h40;
            5'd8:    init_cmd = 8'h8D;
            5'd9:    init_cmd = 8'h14;
            5'd10:   init_cmd = 8'h20;
            5'd11:   init_cmd = 8'h00;
            5'd12:   init_cmd = 8'hA1;
            5'd13:   init_cmd = 8'hC8;
            5'd14:   init_cmd = 8'hDA;
            5'd15:   init_cmd = 8'h12;
            5'd16:   init_cmd = 8'h81;
            5'd17:   init_cmd = 8'hCF;
            5'd18:   init_cmd = 8'hD9;
            5'd19:   init_cmd = 8'hF1;
            5'd20:   init_cmd = 8'hDB;
            5'd21:   init_cmd = 8'h40;
            5'd22:   init_cmd = 8'hA4;
            5'd23:   init_cmd = 8'hA6;
            5'd24:   init_cmd = 8'hAF;
            default: init_cmd = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        next_d      = next_q;
        counter_d   = counter_q;
        sclk_d      = sclk_q;
        sdin_d      = sdin_q;
        cs_d        = cs_q;
        dc_d        = dc_q;
        panel_rst_d = panel_rst_q;
        addr_d      = addr_q;
        bit_d       = bit_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        phase_d     = phase_q;

        case (state_q)
            StInitPower: begin
                counter_d = counter_q + 32'd1;
                if (counter_q < Wait1) begin
                    panel_rst_d = 1'b1;
                end else if (counter_q < Wait2) begin
                    panel_rst_d = 1'b0;
                end else if (counter_q < Wait3) begin
                    panel_rst_d = 1'b1;
                end else begin
                    state_d = StLoadInitCmd;
                end
            end
            StLoadInitCmd: begin
                dc_d    = 1'b0;
                cs_d    = 1'b0;
                bit_d   = 3'd7;
                shift_d = init_cmd;
                next_d  = StCheckFinishedInit;
                state_d = StSend;
            end
            StSend: begin
                // Data only moves on the falling half so it is settled before the rising edge.
                if (!phase_q) begin
                    sclk_d  = 1'b0;
                    sdin_d  = shift_q[bit_q];
                    phase_d = 1'b1;
                end else begin
                    sclk_d  = 1'b1;
                    phase_d = 1'b0;
                    if (bit_q == 3'd0) begin
                        state_d = next_q;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            StCheckFinishedInit: begin
                cs_d = 1'b1;
                if (idx_q == LastCmd) begin
                    state_d = StLoadData;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = StLoadInitCmd;
                end
            end
            StLoadData: begin
                dc_d    = 1'b1;
                cs_d    = 1'b0;
                bit_d   = 3'd7;
                shift_d = pixelData;
                addr_d  = addr_q + 10'd1;
                next_d  = StLoadData;
                state_d = StSend;
            end
            default: state_d = StInitPower;
        endcase
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_q     <= StInitPower;
            next_q      <= StInitPower;
            counter_q   <= 32'd0;
            sclk_q      <= 1'b1;
            sdin_q      <= 1'b0;
            cs_q        <= 1'b1;
            dc_q        <= 1'b1;
            panel_rst_q <= 1'b1;
            addr_q      <= 10'd0;
            bit_q       <= 3'd7;
            idx_q       <= 5'd0;
            shift_q     <= 8'd0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_q      <= next_d;
            counter_q   <= counter_d;
            sclk_q      <= sclk_d;
            sdin_q      <= sdin_d;
            cs_q        <= cs_d;
            dc_q        <= dc_d;
            panel_rst_q <= panel_rst_d;
            addr_q      <= addr_d;
            bit_q       <= bit_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            phase_q     <= phase_d;
        end
    end

    assign ioSclk       = sclk_q;
    assign ioSdin       = sdin_q;
    assign ioCs         = cs_q;
    assign ioDc         = dc_q;
    assign ioReset      = panel_rst_q;
    assign pixelAddress = addr_q;

endmodule

// File: tb/tb_screen.sv
// Directed bench for screen: power-up timing, init command list, frame streaming with wrap,
// SPI protocol integrity and asynchronous mid-byte reset.
module tb_screen;

    logic       clk;
    logic       rst_btn;
    logic       ioSclk;
    logic       ioSdin;
    logic       ioCs;
    logic       ioDc;
    logic       ioReset;
    logic [9:0] pixelAddress;
    logic [7:0] pixelData;

    int checks = 0;
    int errors = 0;

    logic [7:0] cmd_tab [25] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1,
        8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    // Captured traffic, filled by the negedge sampler below.
    logic [7:0] bytes [$];
    logic       dcs [$];
    logic [9:0] addrs [$];
    int         gaps [$];
    int         proto_err = 0;
    int         bound_err = 0;
    logic       prev_sclk, prev_sdin, prev_cs;
    logic [9:0] prev_addr;
    logic [7:0] sh;
    int         bitcnt, since_addr;

    screen #(
        .STARTUP_WAIT(10)
    ) dut (
        .clk         (clk),
        .rst_btn     (rst_btn),
        .ioSclk      (ioSclk),
        .ioSdin      (ioSdin),
        .ioCs        (ioCs),
        .ioDc        (ioDc),
        .ioReset     (ioReset),
        .pixelAddress(pixelAddress),
        .pixelData   (pixelData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame source: one cycle of registered latency.
    always_ff @(posedge clk) pixelData <= pixelAddress[7:0] ^ 8'h5A;

    always @(negedge clk) begin
        if (!rst_btn) begin
            prev_sclk  = 1'b1;
            prev_sdin  = 1'b0;
            prev_cs    = 1'b1;
            prev_addr  = 10'd0;
            sh         = 8'd0;
            bitcnt     = 0;
            since_addr = 0;
        end else begin
            since_addr++;
            if (prev_sclk && ioSclk && (ioSdin !== prev_sdin)) proto_err++;
            if (!prev_sclk && ioSclk) begin
                sh = {sh[6:0], ioSdin};
                bitcnt++;
                if (bitcnt == 8) begin
                    bytes.push_back(sh);
                    dcs.push_back(ioDc);
                    bitcnt = 0;
                end
            end
            if (!prev_cs && ioCs && bitcnt != 0) bound_err++;
            if (pixelAddress != prev_addr) begin
                if (bitcnt != 0) bound_err++;
                addrs.push_back(pixelAddress);
                gaps.push_back(since_addr);
                since_addr = 0;
            end
            prev_sclk = ioSclk;
            prev_sdin = ioSdin;
            prev_cs   = ioCs;
            prev_addr = pixelAddress;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Releases reset and checks edges 0..31: ioReset low for 10..19, ioCs falls at edge 31.
    task automatic run_powerup(input string pfx);
        @(negedge clk);
        rst_btn = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_ioReset_%0d", pfx, k), 32'(ioReset),
                  (k < 10 || k >= 20) ? 32'd1 : 32'd0);
            check($sformatf("%s_ioCs_%0d", pfx, k), 32'(ioCs), (k == 31) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        rst_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ioSclk", 32'(ioSclk), 32'd1);
        check("rst_ioSdin", 32'(ioSdin), 32'd0);
        check("rst_ioCs", 32'(ioCs), 32'd1);
        check("rst_ioDc", 32'(ioDc), 32'd1);
        check("rst_ioReset", 32'(ioReset), 32'd1);
        check("rst_addr", 32'(pixelAddress), 32'd0);

        run_powerup("pwr");

        // Edge 32: first falling SCLK carries AE bit7 = 1, command mode.
        @(posedge clk);
        #1;
        check("e32_sclk", 32'(ioSclk), 32'd0);
        check("e32_sdin", 32'(ioSdin), 32'd1);
        check("e32_dc", 32'(ioDc), 32'd0);
        @(posedge clk);
        #1;
        check("e33_sclk", 32'(ioSclk), 32'd1);
        check("e33_sdin", 32'(ioSdin), 32'd1);
        @(posedge clk);
        #1;
        check("e34_sdin", 32'(ioSdin), 32'd0);
        repeat (14) @(posedge clk);
        #1;
        check("e48_cs_high", 32'(ioCs), 32'd1);
        @(posedge clk);
        #1;
        check("e49_cs_low", 32'(ioCs), 32'd0);

        // 25 command bytes plus 1026 data bytes, covering the 1023 -> 0 wrap.
        for (int c = 0; c < 20000 && bytes.size() < 1051; c++) @(posedge clk);
        #1;
        check("stream_bytes_seen", 32'(bytes.size() >= 1051), 32'd1);
        if (bytes.size() >= 1051) begin
            for (int i = 0; i < 25; i++) begin
                check($sformatf("cmd_byte_%0d", i), 32'(bytes[i]), 32'(cmd_tab[i]));
                check($sformatf("cmd_dc_%0d", i), 32'(dcs[i]), 32'd0);
            end
            for (int j = 0; j < 1026; j++) begin
                logic [9:0] a;
                a = 10'(j % 1024);
                check($sformatf("data_byte_%0d", j), 32'(bytes[25 + j]), 32'(a[7:0] ^ 8'h5A));
                check($sformatf("data_dc_%0d", j), 32'(dcs[25 + j]), 32'd1);
            end
            for (int i = 0; i < 1025; i++) begin
                check($sformatf("addr_%0d", i), 32'(addrs[i]), 32'((i + 1) % 1024));
                if (i > 0) check($sformatf("addr_gap_%0d", i), 32'(gaps[i]), 32'd17);
            end
        end
        check("proto_sdin_stable", 32'(proto_err), 32'd0);
        check("proto_8_rises", 32'(bound_err), 32'd0);

        // Reset asynchronously while SCLK is low inside a data byte.
        for (int c = 0; c < 40 && ioSclk !== 1'b0; c++) begin
            @(posedge clk);
            #1;
        end
        check("mid_pre_sclk_low", 32'(ioSclk), 32'd0);
        check("mid_pre_addr_nz", 32'(pixelAddress != 10'd0), 32'd1);
        #2;
        rst_btn = 1'b0;
        #1;
        check("mid_ioCs", 32'(ioCs), 32'd1);
        check("mid_ioSclk", 32'(ioSclk), 32'd1);
        check("mid_ioReset", 32'(ioReset), 32'd1);
        check("mid_addr", 32'(pixelAddress), 32'd0);
        check("mid_ioDc", 32'(ioDc), 32'd1);
        repeat (3) @(posedge clk);
        bytes.delete();
        dcs.delete();

        run_powerup("re_pwr");
        for (int c = 0; c < 200 && bytes.size() < 2; c++) @(posedge clk);
        #1;
        check("re_bytes_seen", 32'(bytes.size() >= 2), 32'd1);
        if (bytes.size() >= 2) begin
            check("re_cmd0", 32'(bytes[0]), 32'hAE);
            check("re_cmd1", 32'(bytes[1]), 32'hD5);
            check("re_dc0", 32'(dcs[0]), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
